// File: rtl/ahb_mon_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_mon_pkg : shared AHB-Lite encodings, FSM type and check indices for the
//               AES-AHB subordinate protocol monitor.
// Revision    : 1.0
// ---------------------------------------------------------------------------
package ahb_mon_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_WAIT = 2'd1,
      D_ERR2 = 2'd2
   } dstate_e;

   localparam int CHK_ILL_NO_ERR   = 0;
   localparam int CHK_ERR_PROTO    = 1;
   localparam int CHK_WAIT_TMO     = 2;
   localparam int CHK_TRIG_NOSTALL = 3;
   localparam int CHK_HRESP_IDLE   = 4;
   localparam int NUM_CHK          = 5;

   function automatic logic burst_ok(input logic [2:0] burst);
      return (burst == HBURST_SINGLE) || (burst == HBURST_INCR4) || (burst == HBURST_INCR8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mon_sat_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_mon_sat_cnt : saturating up-counter with synchronous clear.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module ahb_mon_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   // A clear that coincides with an increment restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= WIDTH'(i_inc);
      end else if (i_inc && !(&r_count)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ahb_protocol_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_protocol_monitor : passive AHB-Lite subordinate-side protocol checker
//                        with sticky flags and saturating event counters.
// Revision             : 1.0
// ---------------------------------------------------------------------------
module ahb_protocol_monitor #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] MAX_ADDR    = 32'h3C,
   parameter logic [2:0]        SIZE_OK     = 3'b010,
   parameter int                MAX_WAIT    = 16,
   parameter logic [ADDR_W-1:0] TRIG_ADDR   = 32'h2C,
   parameter int                TRIG_WINDOW = 2,
   parameter int                CNT_W       = 16
) (
   input  logic              hclk,
   input  logic              hrst,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic              hready,
   input  logic              hreadyout,
   input  logic              hresp,
   input  logic              clr,
   output logic [4:0]        viol_flags,
   output logic              viol_any,
   output logic [CNT_W-1:0]  viol_count,
   output logic [CNT_W-1:0]  xfer_count
);

   import ahb_mon_pkg::*;

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int TRIG_W = $clog2(TRIG_WINDOW + 1);

   dstate_e              r_state;
   dstate_e              w_state_nxt;
   logic                 r_ill_q;
   logic [WAIT_W-1:0]    r_wait_cnt;
   logic [TRIG_W-1:0]    r_trig_cnt;
   logic [NUM_CHK-1:0]   r_flags;
   logic                 r_any;
   logic [NUM_CHK-1:0]   w_det;
   logic                 w_accept;
   logic                 w_illegal;
   logic                 w_trig_start;
   logic                 w_active;
   logic                 w_done;
   logic                 w_wait_fire;
   logic                 w_trig_fire;

   assign w_accept     = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
   assign w_illegal    = (haddr > MAX_ADDR) || (hsize != SIZE_OK) || !burst_ok(hburst);
   assign w_trig_start = w_accept && hwrite && (haddr == TRIG_ADDR);
   assign w_active     = (r_state == D_WAIT) || (r_state == D_ERR2);

   // Fires on the MAX_WAIT-th consecutive stalled cycle; the counter then parks.
   assign w_wait_fire  = w_active && !hreadyout && (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));
   assign w_trig_fire  = !w_trig_start && (r_trig_cnt == TRIG_W'(1)) && hreadyout;

   always_comb begin
      w_state_nxt = r_state;
      w_det       = '0;
      w_done      = 1'b0;
      case (r_state)
         D_IDLE: begin
            if (hresp == HRESP_ERROR) w_det[CHK_HRESP_IDLE] = 1'b1;
            if (w_accept) w_state_nxt = D_WAIT;
         end
         D_WAIT: begin
            if (hreadyout) begin
               w_done      = 1'b1;
               w_state_nxt = w_accept ? D_WAIT : D_IDLE;
               if (hresp == HRESP_ERROR) w_det[CHK_ERR_PROTO] = 1'b1;
            end else if (hresp == HRESP_ERROR) begin
               w_state_nxt = D_ERR2;
            end
         end
         D_ERR2: begin
            if (!(hresp && hreadyout)) w_det[CHK_ERR_PROTO] = 1'b1;
            if (hreadyout) begin
               w_done      = 1'b1;
               w_state_nxt = w_accept ? D_WAIT : D_IDLE;
            end
         end
         default: w_state_nxt = D_IDLE;
      endcase
      if (w_done && r_ill_q && (hresp == HRESP_OKAY)) w_det[CHK_ILL_NO_ERR] = 1'b1;
      if (w_wait_fire) w_det[CHK_WAIT_TMO]     = 1'b1;
      if (w_trig_fire) w_det[CHK_TRIG_NOSTALL] = 1'b1;
   end

   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         r_state    <= D_IDLE;
         r_ill_q    <= 1'b0;
         r_wait_cnt <= '0;
         r_trig_cnt <= '0;
         r_flags    <= '0;
         r_any      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_ill_q <= w_illegal;

         if (!w_active || hreadyout) begin
            r_wait_cnt <= '0;
         end else if (r_wait_cnt < WAIT_W'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end

         // Any stall inside the window satisfies the trigger, so the window closes early.
         if (w_trig_start) begin
            r_trig_cnt <= TRIG_W'(TRIG_WINDOW);
         end else if (r_trig_cnt != '0) begin
            r_trig_cnt <= hreadyout ? (r_trig_cnt - 1'b1) : '0;
         end

         r_flags <= clr ? w_det : (r_flags | w_det);
         r_any   <= |r_flags;
      end
   end

   ahb_mon_sat_cnt #(.WIDTH(CNT_W)) u_viol_cnt (
      .clk     (hclk),
      .rst     (hrst),
      .i_clr   (clr),
      .i_inc   (|w_det),
      .o_count (viol_count)
   );

   ahb_mon_sat_cnt #(.WIDTH(CNT_W)) u_xfer_cnt (
      .clk     (hclk),
      .rst     (hrst),
      .i_clr   (clr),
      .i_inc   (w_done),
      .o_count (xfer_count)
   );

   assign viol_flags = r_flags;
   assign viol_any   = r_any;

endmodule
`default_nettype wire

// File: tb/tb_ahb_protocol_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ahb_protocol_monitor : directed stimulus against a transaction-level
//                           reference of the monitor's rules.
// Revision                : 1.0
// ---------------------------------------------------------------------------
module tb_ahb_protocol_monitor;

   localparam int          MAX_WAIT    = 16;
   localparam int          TRIG_WINDOW = 2;
   localparam logic [31:0] MAX_ADDR    = 32'h3C;
   localparam logic [31:0] TRIG_ADDR   = 32'h2C;

   logic        hclk      = 1'b0;
   logic        hrst      = 1'b1;
   logic        hsel      = 1'b0;
   logic [31:0] haddr     = '0;
   logic [1:0]  htrans    = 2'b00;
   logic        hwrite    = 1'b0;
   logic [2:0]  hsize     = 3'b010;
   logic [2:0]  hburst    = 3'b000;
   logic        hready    = 1'b1;
   logic        hreadyout = 1'b1;
   logic        hresp     = 1'b0;
   logic        clr       = 1'b0;
   logic [4:0]  viol_flags;
   logic        viol_any;
   logic [15:0] viol_count;
   logic [15:0] xfer_count;

   int n_total = 0;
   int n_pass  = 0;

   ahb_protocol_monitor #(
      .ADDR_W(32), .MAX_ADDR(MAX_ADDR), .SIZE_OK(3'b010), .MAX_WAIT(MAX_WAIT),
      .TRIG_ADDR(TRIG_ADDR), .TRIG_WINDOW(TRIG_WINDOW), .CNT_W(16)
   ) dut (
      .hclk(hclk), .hrst(hrst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(hready),
      .hreadyout(hreadyout), .hresp(hresp), .clr(clr), .viol_flags(viol_flags),
      .viol_any(viol_any), .viol_count(viol_count), .xfer_count(xfer_count)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: one outstanding data phase, the ERROR history of that phase,
   // a run length of stalled cycles and a countdown of remaining trigger cycles.
   bit         m_phase = 0, m_ill = 0, m_err_seen = 0, m_trig_stalled = 0;
   int         m_low_run = 0, m_trig_left = 0, m_viol = 0, m_xfer = 0;
   logic [4:0] m_flags = '0;
   logic       m_any = 1'b0;
   logic [4:0] m_det;
   bit         m_acc, m_done, m_illegal, m_trig;

   initial forever begin
      @(posedge hclk or posedge hrst);
      if (hrst) begin
         m_phase = 0; m_ill = 0; m_err_seen = 0; m_trig_stalled = 0;
         m_low_run = 0; m_trig_left = 0; m_viol = 0; m_xfer = 0;
         m_flags = '0; m_any = 1'b0;
      end else begin
         m_acc     = hsel && hready && htrans[1];
         m_illegal = (haddr > MAX_ADDR) || (hsize != 3'b010) ||
                     !(hburst inside {3'b000, 3'b011, 3'b101});
         m_trig    = m_acc && hwrite && (haddr == TRIG_ADDR);
         m_det     = '0;
         m_done    = 0;
         if (!m_phase) begin
            if (hresp) m_det[4] = 1'b1;
         end else begin
            if (m_err_seen) begin
               if (!(hresp && hreadyout)) m_det[1] = 1'b1;
            end else if (hresp && hreadyout) begin
               m_det[1] = 1'b1;
            end
            if (hreadyout && !hresp && m_ill) m_det[0] = 1'b1;
            if (!hreadyout) begin
               m_low_run++;
               if (m_low_run == MAX_WAIT) m_det[2] = 1'b1;
            end
            if (hresp && !hreadyout) m_err_seen = 1;
            m_done = hreadyout;
         end
         if (!m_phase || hreadyout) m_low_run = 0;

         if (m_trig) begin
            m_trig_left    = TRIG_WINDOW;
            m_trig_stalled = 0;
         end else if (m_trig_left > 0) begin
            if (!hreadyout) m_trig_stalled = 1;
            m_trig_left--;
            if (m_trig_left == 0 && !m_trig_stalled) m_det[3] = 1'b1;
         end

         if (m_acc) m_ill = m_illegal;
         if (m_done || !m_phase) begin
            m_phase    = m_acc;
            m_err_seen = 0;
         end

         m_any   = |m_flags;
         m_flags = clr ? m_det : (m_flags | m_det);
         if (clr) m_viol = (m_det != 0) ? 1 : 0;
         else if (m_det != 0 && m_viol < 65535) m_viol++;
         if (clr) m_xfer = m_done ? 1 : 0;
         else if (m_done && m_xfer < 65535) m_xfer++;
      end
   end

   always @(negedge hclk) begin
      if (!hrst) begin
         check("model_flags", 32'(viol_flags), 32'(m_flags));
         check("model_any",   32'(viol_any),   32'(m_any));
         check("model_viol",  32'(viol_count), 32'(m_viol));
         check("model_xfer",  32'(xfer_count), 32'(m_xfer));
      end
   end

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic idle_bus();
      hsel = 0; htrans = 2'b00; haddr = '0; hwrite = 0; hsize = 3'b010; hburst = 3'b000;
   endtask

   task automatic addr(input logic [31:0] a, input logic w);
      hsel = 1; htrans = 2'b10; haddr = a; hwrite = w; hsize = 3'b010; hburst = 3'b000;
      hready = 1; hreadyout = 1; hresp = 0;
      tick();
      idle_bus();
   endtask

   task automatic data(input logic ro, input logic resp);
      hreadyout = ro; hready = ro; hresp = resp;
      tick();
   endtask

   task automatic idle(input int n);
      hreadyout = 1; hready = 1; hresp = 0;
      repeat (n) tick();
   endtask

   task automatic do_clr();
      clr = 1; idle(1); clr = 0;
   endtask

   initial begin
      repeat (3) tick();
      hrst = 0;
      tick();
      check("rst_flags", 32'(viol_flags), 32'h0);
      check("rst_any",   32'(viol_any),   32'h0);
      check("rst_viol",  32'(viol_count), 32'h0);
      check("rst_xfer",  32'(xfer_count), 32'h0);

      addr(32'h10, 1); data(1, 0);
      check("legal_xfer",  32'(xfer_count), 32'd1);
      check("legal_flags", 32'(viol_flags), 32'h0);

      addr(32'h40, 0); data(0, 1); data(1, 1);
      check("ill_err_flags", 32'(viol_flags), 32'h0);
      check("ill_err_xfer",  32'(xfer_count), 32'd2);

      addr(32'h40, 0); data(1, 0);
      check("ill_okay_flags", 32'(viol_flags), 32'b00001);
      check("ill_okay_viol",  32'(viol_count), 32'd1);
      idle(1);
      check("ill_okay_any", 32'(viol_any), 32'h1);
      do_clr();

      addr(TRIG_ADDR, 1); data(1, 0);
      check("trig_early", 32'(viol_flags), 32'h0);
      idle(1);
      check("trig_flag", 32'(viol_flags), 32'b01000);
      do_clr();

      addr(TRIG_ADDR, 1); data(1, 0); data(0, 0); idle(3);
      check("trig_stall_flags", 32'(viol_flags), 32'h0);
      check("trig_stall_xfer",  32'(xfer_count), 32'd1);

      addr(32'h10, 0);
      repeat (20) data(0, 0);
      data(1, 0);
      check("tmo_flags", 32'(viol_flags), 32'b00100);
      check("tmo_viol",  32'(viol_count), 32'd1);
      check("tmo_xfer",  32'(xfer_count), 32'd2);
      do_clr();

      data(1, 1); data(1, 0); data(1, 1); data(1, 0);
      check("hresp_idle_flags", 32'(viol_flags), 32'b10000);
      check("hresp_idle_viol",  32'(viol_count), 32'd2);
      do_clr();
      check("clr_flags", 32'(viol_flags), 32'h0);
      check("clr_viol",  32'(viol_count), 32'h0);
      check("clr_xfer",  32'(xfer_count), 32'h0);
      clr = 1; data(1, 1); clr = 0; hresp = 0;
      check("clr_coll_flags", 32'(viol_flags), 32'b10000);
      check("clr_coll_viol",  32'(viol_count), 32'd1);
      idle(1);
      check("clr_coll_any", 32'(viol_any), 32'h1);

      addr(32'h10, 1); data(1, 1);
      check("one_cyc_err_flags", 32'(viol_flags), 32'b10010);
      check("one_cyc_err_viol",  32'(viol_count), 32'd2);

      // Pipelined pair: the second (illegal) address is accepted as the first completes.
      hsel = 1; htrans = 2'b10; haddr = 32'h10; hwrite = 0; hready = 1; hreadyout = 1; hresp = 0;
      tick();
      htrans = 2'b11; haddr = 32'h3D; hburst = 3'b011;
      tick();
      idle_bus();
      tick();
      check("pipe_flags", 32'(viol_flags), 32'b10011);
      check("pipe_xfer",  32'(xfer_count), 32'd3);

      addr(32'h10, 0); data(0, 0);
      hrst = 1;
      tick();
      idle_bus(); hreadyout = 1; hready = 1; hresp = 0;
      hrst = 0;
      idle(2);
      check("rst_mid_flags", 32'(viol_flags), 32'h0);
      check("rst_mid_any",   32'(viol_any),   32'h0);
      check("rst_mid_viol",  32'(viol_count), 32'h0);
      check("rst_mid_xfer",  32'(xfer_count), 32'h0);

      hsel = 1; htrans = 2'b10; haddr = 32'h10; hwrite = 1; hready = 1; hreadyout = 1; hresp = 0;
      repeat (70000) tick();
      idle_bus();
      tick();
      check("sat_xfer",  32'(xfer_count), 32'hFFFF);
      check("sat_viol",  32'(viol_count), 32'h0);
      check("sat_flags", 32'(viol_flags), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
